// File: rtl/line_row_feeder_if.sv
// Pixel stream in, three-row column stream out, between a raster source and
// the 3x3 window generator. slave is the feeder side, master the source/sink side.
interface line_row_feeder_if #(
  parameter int IMG_W  = 64,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0]        pix_in;
  logic                     pix_valid;
  logic                     sof;
  logic [DATA_W-1:0]        r0;
  logic [DATA_W-1:0]        r1;
  logic [DATA_W-1:0]        r2;
  logic                     out_valid;
  logic [$clog2(IMG_W)-1:0] out_col;
  logic                     eol;
  logic                     frame_done;

  modport slave (
    input  pix_in, pix_valid, sof,
    output r0, r1, r2, out_valid, out_col, eol, frame_done
  );

  modport master (
    output pix_in, pix_valid, sof,
    input  r0, r1, r2, out_valid, out_col, eol, frame_done
  );
endinterface

// File: rtl/line_row_feeder.sv
// Two-line-buffer row feeder: presents rows y-2, y-1, y of the same column one
// cycle after each accepted raster pixel.
module line_row_feeder #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int DATA_W = 8
) (
  input logic              clk,
  input logic              rst,
  line_row_feeder_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];

  logic [CW-1:0] col, x, col_nxt;
  logic [RW-1:0] row, y, row_nxt;

  logic [DATA_W-1:0] r0_q, r1_q, r2_q;
  logic [CW-1:0]     out_col_q;
  logic              out_valid_q, eol_q, frame_done_q;

  // sof overrides the counters for the position of the pixel it qualifies.
  always_comb begin
    x = bus.sof ? '0 : col;
    y = bus.sof ? '0 : row;
    if (x == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (y == ROW_LAST) ? '0 : y + 1'b1;
    end else begin
      col_nxt = x + 1'b1;
      row_nxt = y;
    end
  end

  // Buffers are never reset; reads are only trusted once two rows are written.
  always_ff @(posedge clk) begin
    if (!rst && bus.pix_valid) begin
      lb0[x] <= lb1[x];
      lb1[x] <= bus.pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      r0_q         <= '0;
      r1_q         <= '0;
      r2_q         <= '0;
      out_col_q    <= '0;
      out_valid_q  <= 1'b0;
      eol_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (bus.pix_valid) begin
      col          <= col_nxt;
      row          <= row_nxt;
      r0_q         <= lb0[x];
      r1_q         <= lb1[x];
      r2_q         <= bus.pix_in;
      out_col_q    <= x;
      out_valid_q  <= (y >= ROW_TWO);
      eol_q        <= (x == COL_LAST) && (y >= ROW_TWO);
      frame_done_q <= (x == COL_LAST) && (y == ROW_LAST);
    end else begin
      out_valid_q  <= 1'b0;
      eol_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end
  end

  assign bus.r0         = r0_q;
  assign bus.r1         = r1_q;
  assign bus.r2         = r2_q;
  assign bus.out_col    = out_col_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.eol        = eol_q;
  assign bus.frame_done = frame_done_q;
endmodule
